// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: 16-byte instruction fetch queue with a single-outstanding byte fetch FSM.
// Ports: clk, reset (async, active-high); mem_req/mem_addr/mem_ack/mem_data byte fetch port;
// inst_take/inst_len consume 1-3 head bytes; flush/flush_addr redirect; q_byte0-2 head bytes,
// q_count fill level 0-16, q_pc address of q_byte0.
// Optional: define FETCH_QUEUE_FLUSH_COUNT_EN to add an 8-bit saturating flush_count output.
module fetch_queue_ctrl #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  input  logic        inst_take,
  input  logic [1:0]  inst_len,
  input  logic        flush,
  input  logic [15:0] flush_addr,
  output logic [7:0]  q_byte0,
  output logic [7:0]  q_byte1,
  output logic [7:0]  q_byte2,
  output logic [4:0]  q_count,
  output logic [15:0] q_pc
`ifdef FETCH_QUEUE_FLUSH_COUNT_EN
  ,
  output logic [7:0]  flush_count
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
  state_t state_q, state_d;
  logic [3:0] ptr_s_q, ptr_s_d, ptr_e_q, ptr_e_d;
  logic [4:0] count_q, count_d;
  logic [15:0] pc_q, pc_d, addr_q, addr_d;
  logic req_q;
  logic [7:0] mem_q [16];
  logic push, take_ok;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ptr_s_q <= '0;
      ptr_e_q <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= state_d != IDLE;
      ptr_s_q <= ptr_s_d;
      ptr_e_q <= ptr_e_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_e_q] <= mem_data;
  end
  // An ack always closes the outstanding request; a flush without one must wait it out in DROP.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = (!flush && count_q < 5'd16) ? BUSY : IDLE;
      BUSY:    state_d = mem_ack ? IDLE : flush ? DROP : BUSY;
      DROP:    state_d = mem_ack ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    take_ok = inst_take && inst_len != 2'd0 && count_q >= {3'b0, inst_len} && !flush;
    push    = state_q == BUSY && mem_ack && !flush && count_q != 5'd16;
    ptr_e_d = ptr_e_q + {3'b0, push};
    ptr_s_d = flush ? ptr_e_q : take_ok ? ptr_s_q + {2'b0, inst_len} : ptr_s_q;
    count_d = flush ? 5'd0 : count_q + {4'b0, push} - (take_ok ? {3'b0, inst_len} : 5'd0);
    pc_d    = flush ? flush_addr : take_ok ? pc_q + {14'b0, inst_len} : pc_q;
    addr_d  = flush ? flush_addr : push ? addr_q + 16'd1 : addr_q;
  end
  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign q_count  = count_q;
  assign q_pc     = pc_q;
  assign q_byte0  = mem_q[ptr_s_q];
  assign q_byte1  = mem_q[ptr_s_q + 4'd1];
  assign q_byte2  = mem_q[ptr_s_q + 4'd2];
`ifdef FETCH_QUEUE_FLUSH_COUNT_EN
  logic [7:0] flush_count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flush_count_q <= '0;
    else if (flush && flush_count_q != 8'hFF) flush_count_q <= flush_count_q + 8'd1;
  end
  assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb_fetch_queue_ctrl: table-driven and directed checks of fetch_queue_ctrl.
module tb_fetch_queue_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_req, mem_ack = 1'b0, inst_take = 1'b0, flush = 1'b0;
  logic [15:0] mem_addr, flush_addr = '0, q_pc;
  logic [7:0] mem_data = '0, q_byte0, q_byte1, q_byte2;
  logic [1:0] inst_len = '0;
  logic [4:0] q_count;
`ifdef FETCH_QUEUE_FLUSH_COUNT_EN
  logic [7:0] flush_count;
`endif
  int checks = 0, errors = 0;
  fetch_queue_ctrl dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .inst_take(inst_take), .inst_len(inst_len),
    .flush(flush), .flush_addr(flush_addr), .q_byte0(q_byte0), .q_byte1(q_byte1),
    .q_byte2(q_byte2), .q_count(q_count), .q_pc(q_pc)
`ifdef FETCH_QUEUE_FLUSH_COUNT_EN
    , .flush_count(flush_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic fl; logic [15:0] fa; logic tk; logic [1:0] ln; logic ak; logic [7:0] d;
    logic [4:0] ec; logic [15:0] epc; logic er; logic [15:0] ea; logic [7:0] eb;
  } vec_t;
  vec_t v[25];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      flush = v[i].fl; flush_addr = v[i].fa; inst_take = v[i].tk; inst_len = v[i].ln;
      mem_ack = v[i].ak; mem_data = v[i].d;
      @(negedge clk);
      chk($sformatf("r%0d count", i), {11'b0, q_count}, {11'b0, v[i].ec});
      chk($sformatf("r%0d pc", i), q_pc, v[i].epc);
      chk($sformatf("r%0d req", i), {15'b0, mem_req}, {15'b0, v[i].er});
      chk($sformatf("r%0d addr", i), mem_addr, v[i].ea);
      if (v[i].ec != 5'd0) chk($sformatf("r%0d byte0", i), {8'b0, q_byte0}, {8'b0, v[i].eb});
    end
    flush = 0; inst_take = 0; inst_len = 0; mem_ack = 0;
  endtask
  task automatic do_reset();
    flush = 0; inst_take = 0; inst_len = 0; mem_ack = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    v[0]  = '{0, 16'h0000, 0, 0, 1, 8'hA9, 0, 16'hFFFC, 1, 16'hFFFC, 8'h00};
    v[1]  = '{0, 16'h0000, 0, 0, 1, 8'hA9, 1, 16'hFFFC, 0, 16'hFFFD, 8'hA9};
    v[2]  = '{0, 16'h0000, 0, 0, 1, 8'h05, 1, 16'hFFFC, 1, 16'hFFFD, 8'hA9};
    v[3]  = '{0, 16'h0000, 0, 0, 1, 8'h05, 2, 16'hFFFC, 0, 16'hFFFE, 8'hA9};
    v[4]  = '{0, 16'h0000, 0, 0, 1, 8'h8D, 2, 16'hFFFC, 1, 16'hFFFE, 8'hA9};
    v[5]  = '{0, 16'h0000, 0, 0, 1, 8'h8D, 3, 16'hFFFC, 0, 16'hFFFF, 8'hA9};
    v[6]  = '{0, 16'h0000, 1, 3, 0, 8'h00, 0, 16'hFFFF, 1, 16'hFFFF, 8'h00};
    v[7]  = '{0, 16'h0000, 0, 0, 1, 8'h11, 1, 16'hFFFF, 0, 16'h0000, 8'h11};
    v[8]  = '{0, 16'h0000, 1, 2, 0, 8'h00, 1, 16'hFFFF, 1, 16'h0000, 8'h11};
    v[9]  = '{0, 16'h0000, 1, 1, 1, 8'h22, 1, 16'h0000, 0, 16'h0001, 8'h22};
    v[10] = '{0, 16'h0000, 1, 0, 0, 8'h00, 1, 16'h0000, 1, 16'h0001, 8'h22};
    v[11] = '{1, 16'h1234, 1, 1, 0, 8'h00, 0, 16'h1234, 1, 16'h1234, 8'h00};
    v[12] = '{0, 16'h0000, 0, 0, 0, 8'h00, 0, 16'h1234, 1, 16'h1234, 8'h00};
    v[13] = '{0, 16'h0000, 0, 0, 1, 8'h55, 0, 16'h1234, 0, 16'h1234, 8'h00};
    v[14] = '{0, 16'h0000, 0, 0, 0, 8'h00, 0, 16'h1234, 1, 16'h1234, 8'h00};
    v[15] = '{1, 16'h4000, 0, 0, 1, 8'h66, 0, 16'h4000, 0, 16'h4000, 8'h00};
    v[16] = '{0, 16'h0000, 0, 0, 0, 8'h00, 0, 16'h4000, 1, 16'h4000, 8'h00};
    v[17] = '{1, 16'h5000, 0, 0, 0, 8'h00, 0, 16'h5000, 1, 16'h5000, 8'h00};
    v[18] = '{1, 16'h6000, 0, 0, 0, 8'h00, 0, 16'h6000, 1, 16'h6000, 8'h00};
    v[19] = '{0, 16'h0000, 0, 0, 1, 8'h77, 0, 16'h6000, 0, 16'h6000, 8'h00};
    v[20] = '{0, 16'h0000, 0, 0, 0, 8'h00, 0, 16'h6000, 1, 16'h6000, 8'h00};
    v[21] = '{0, 16'h0000, 0, 0, 1, 8'h88, 1, 16'h6000, 0, 16'h6001, 8'h88};
    v[22] = '{0, 16'h0000, 0, 0, 0, 8'h00, 1, 16'h6000, 1, 16'h6001, 8'h88};
    v[23] = '{0, 16'h0000, 0, 0, 1, 8'h99, 2, 16'h6000, 0, 16'h6002, 8'h88};
    v[24] = '{0, 16'h0000, 1, 3, 0, 8'h00, 2, 16'h6000, 1, 16'h6002, 8'h88};
    repeat (2) @(negedge clk);
    chk("reset count", {11'b0, q_count}, 16'd0);
    chk("reset req", {15'b0, mem_req}, 16'd0);
    chk("reset addr", mem_addr, 16'hFFFC);
    chk("reset pc", q_pc, 16'hFFFC);
    reset = 0;
    run_rows(0, 5);
    chk("boot byte1", {8'b0, q_byte1}, 16'h0005);
    chk("boot byte2", {8'b0, q_byte2}, 16'h008D);
    run_rows(6, 24);
    // async reset in BUSY, then a stray ack while IDLE
    #2 reset = 1;
    #1;
    chk("async rst req", {15'b0, mem_req}, 16'd0);
    chk("async rst count", {11'b0, q_count}, 16'd0);
    chk("async rst addr", mem_addr, 16'hFFFC);
    chk("async rst pc", q_pc, 16'hFFFC);
    @(negedge clk);
    reset = 0; mem_ack = 1; mem_data = 8'hEE;
    @(negedge clk);
    chk("stray ack count", {11'b0, q_count}, 16'd0);
    chk("stray ack req", {15'b0, mem_req}, 16'd1);
    // fill to 16
    do_reset();
    begin
      int n = 0;
      mem_ack = 1;
      for (int c = 0; c < 100 && q_count != 5'd16; c++) begin
        if (mem_req) begin mem_data = n[7:0]; n++; end
        @(negedge clk);
      end
      chk("fill count", {11'b0, q_count}, 16'd16);
      repeat (3) @(negedge clk);
      chk("full count", {11'b0, q_count}, 16'd16);
      chk("full req", {15'b0, mem_req}, 16'd0);
      chk("full addr", mem_addr, 16'h000C);
      mem_ack = 0; inst_take = 1; inst_len = 3;
      @(negedge clk);
      inst_take = 0;
      chk("take3 count", {11'b0, q_count}, 16'd13);
      chk("take3 pc", q_pc, 16'hFFFF);
      chk("take3 byte0", {8'b0, q_byte0}, 16'h0003);
      @(negedge clk);
      chk("resume req", {15'b0, mem_req}, 16'd1);
      chk("resume addr", mem_addr, 16'h000C);
    end
    // wrap: 20 pushes and 20 pops of length 1
    do_reset();
    begin
      int n = 0, p = 0;
      for (int c = 0; c < 300 && p < 20; c++) begin
        inst_take = q_count != 5'd0; inst_len = 1;
        if (inst_take) begin
          chk($sformatf("wrap pop%0d", p), {8'b0, q_byte0}, {8'b0, 8'hC0 + p[7:0]});
          p++;
        end
        mem_ack = mem_req && n < 20;
        if (mem_ack) begin mem_data = 8'hC0 + n[7:0]; n++; end
        @(negedge clk);
      end
      inst_take = 0; mem_ack = 0;
      chk("wrap pops", p[15:0], 16'd20);
      chk("wrap count", {11'b0, q_count}, 16'd0);
      chk("wrap pc", q_pc, 16'hFFFC + 16'd20);
    end
`ifdef FETCH_QUEUE_FLUSH_COUNT_EN
    do_reset();
    chk("fcount reset", {8'b0, flush_count}, 16'd0);
    flush = 1;
    repeat (300) @(negedge clk);
    flush = 0;
    chk("fcount sat", {8'b0, flush_count}, 16'h00FF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
